// File: rtl/sin_share_scheduler_pkg.sv
// Shared widths, default sine-unit latency and scheduler state encodings
// for the shared sine-unit scheduler.
package sin_share_scheduler_pkg;
    localparam int SINGLE_W     = 32;
    localparam int PIPE_LAT_DEF = 39;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } sched_state_e;
endpackage

// File: rtl/sin_tag_delay.sv
// {valid, tag} shift register that tracks which requester owns each result
// emerging from the fixed-latency sine pipeline.
module sin_tag_delay #(
    parameter int DEPTH = 39,
    parameter int TAGW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    output logic [TAGW-1:0] out_tag
);
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [TAGW-1:0]  tag_q [DEPTH];
    logic [TAGW-1:0]  tag_d [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_d[gi] = in_valid;
                assign tag_d[gi]   = in_tag;
            end else begin : g_body
                assign valid_d[gi] = valid_q[gi-1];
                assign tag_d[gi]   = tag_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
endmodule

// File: rtl/sin_share_scheduler.sv
// Round-robin time-sharing of one pipelined sine unit among NREQ requesters,
// with tagged response steering and a halt/drain handshake.
module sin_share_scheduler
    import sin_share_scheduler_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int TAGW     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*SINGLE_W-1:0] theta,
    output logic [NREQ-1:0]          gnt,
    output logic [SINGLE_W-1:0]      sin_theta,
    output logic                     sin_sta,
    input  logic [SINGLE_W-1:0]      sin_result,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [SINGLE_W-1:0]      rsp_sin,
    input  logic                     halt,
    output logic                     halt_ack,
    output logic [5:0]               inflight
);
    sched_state_e          state_q;
    logic                  halt_ack_q;
    logic [NREQ-1:0]       pending_q, pending_d;
    logic [TAGW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SINGLE_W-1:0]   sin_theta_q, sin_theta_d;
    logic                  sin_sta_q, sin_sta_d;
    logic [TAGW-1:0]       tag_q, tag_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [SINGLE_W-1:0]   rsp_sin_q, rsp_sin_d;
    logic [5:0]            inflight_q, inflight_d;

    logic [SINGLE_W-1:0]   theta_arr [NREQ];
    logic [NREQ-1:0]       eligible;
    logic [NREQ-1:0]       gnt_c;
    logic                  arb_en;
    logic                  win_found;
    logic [TAGW-1:0]       win_idx;
    int                    cand;
    logic                  dl_valid;
    logic [TAGW-1:0]       dl_tag;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_theta
            assign theta_arr[gi] = theta[gi*SINGLE_W +: SINGLE_W];
        end
    endgenerate

    // Arbitration is cut off the same cycle halt is seen, not one cycle later.
    assign arb_en   = (state_q == ST_RUN) && !halt;
    assign eligible = req & ~pending_q;

    always_comb begin
        gnt_c     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (arb_en) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (int'(rr_ptr_q) + k >= NREQ) ? int'(rr_ptr_q) + k - NREQ
                                                     : int'(rr_ptr_q) + k;
                if (!win_found && eligible[cand]) begin
                    win_found = 1'b1;
                    win_idx   = TAGW'(cand);
                end
            end
        end
        if (win_found) begin
            gnt_c[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        sin_sta_d   = win_found;
        sin_theta_d = sin_theta_q;
        tag_d       = tag_q;
        if (win_found) begin
            sin_theta_d = theta_arr[win_idx];
            tag_d       = win_idx;
            rr_ptr_d    = (int'(win_idx) == NREQ-1) ? '0 : win_idx + TAGW'(1);
        end
    end

    sin_tag_delay #(
        .DEPTH (PIPE_LAT),
        .TAGW  (TAGW)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sin_sta_q),
        .in_tag    (tag_q),
        .out_valid (dl_valid),
        .out_tag   (dl_tag)
    );

    // sin_result is only trusted when the tag line says a result is due.
    always_comb begin
        rsp_valid_d = '0;
        rsp_sin_d   = rsp_sin_q;
        if (dl_valid) begin
            rsp_valid_d[dl_tag] = 1'b1;
            rsp_sin_d           = sin_result;
        end
    end

    always_comb begin
        pending_d  = (pending_q | gnt_c) & ~rsp_valid_q;
        inflight_d = inflight_q;
        if (win_found && !(|rsp_valid_q)) begin
            inflight_d = inflight_q + 6'd1;
        end else if (!win_found && (|rsp_valid_q)) begin
            inflight_d = inflight_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            sin_theta_q <= '0;
            sin_sta_q   <= 1'b0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_sin_q   <= '0;
            inflight_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            sin_theta_q <= sin_theta_d;
            sin_sta_q   <= sin_sta_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sin_q   <= rsp_sin_d;
            inflight_q  <= inflight_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!halt) begin
                        state_q <= ST_RUN;
                    end else if (inflight_q == 6'd0) begin
                        state_q    <= ST_HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        state_q    <= ST_RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    halt_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_c;
    assign sin_theta = sin_theta_q;
    assign sin_sta   = sin_sta_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sin   = rsp_sin_q;
    assign halt_ack  = halt_ack_q;
    assign inflight  = inflight_q;
endmodule

// File: tb/tb_sin_share_scheduler.sv
// Directed bench for sin_share_scheduler with a behavioural fixed-latency
// sine unit that drives junk whenever its output is not valid.
module tb_sin_share_scheduler;
    localparam int NREQ     = 4;
    localparam int PIPE_LAT = 39;
    localparam int TAGW     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] theta;
    logic [NREQ-1:0]    gnt;
    logic [31:0]        sin_theta;
    logic               sin_sta;
    logic [31:0]        sin_result;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_sin;
    logic               halt;
    logic               halt_ack;
    logic [5:0]         inflight;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [31:0] th [NREQ];

    always #5 clk = ~clk;

    sin_share_scheduler #(
        .NREQ     (NREQ),
        .PIPE_LAT (PIPE_LAT),
        .TAGW     (TAGW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .theta      (theta),
        .gnt        (gnt),
        .sin_theta  (sin_theta),
        .sin_sta    (sin_sta),
        .sin_result (sin_result),
        .rsp_valid  (rsp_valid),
        .rsp_sin    (rsp_sin),
        .halt       (halt),
        .halt_ack   (halt_ack),
        .inflight   (inflight)
    );

    function automatic logic [31:0] sine_model(input logic [31:0] x);
        if (x == 32'h3FC90FDB) return 32'h3F800000;
        return {x[15:0], x[31:16]} ^ 32'h0F0F_0000;
    endfunction

    // Behavioural sine unit: result valid PIPE_LAT cycles after sin_sta.
    logic [31:0]         sp_data [PIPE_LAT];
    logic [PIPE_LAT-1:0] sp_vld;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_vld <= '0;
        end else begin
            sp_vld     <= {sp_vld[PIPE_LAT-2:0], sin_sta};
            sp_data[0] <= sine_model(sin_theta);
            for (int i = 1; i < PIPE_LAT; i++) sp_data[i] <= sp_data[i-1];
        end
    end
    assign sin_result = sp_vld[PIPE_LAT-1] ? sp_data[PIPE_LAT-1] : 32'hDEADBEEF;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Drops all requests and waits (bounded) for the next response.
    task automatic wait_rsp(input string tag, input int g, input logic [3:0] exp_v,
                            input logic [31:0] exp_s);
        int lat;
        lat = -1;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            tick();
            req = '0;
            #1;
            if (rsp_valid != '0) lat = cyc - g;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd41);
        check_val({tag, "_vld"}, {28'd0, rsp_valid}, {28'd0, exp_v});
        check_val({tag, "_sin"}, rsp_sin, exp_s);
    endtask

    initial begin
        int g, z, h, nr, bad_g, stray;
        logic [3:0] exp_g, exp_r;
        logic [3:0] order [3];

        rst = 1'b1; req = '0; halt = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            th[k] = 32'h3F000000 + 32'(k) * 32'h00100000;
            theta[k*32 +: 32] = th[k];
        end
        tick(); tick();
        #1;
        check_val("rst_gnt", {28'd0, gnt}, 32'd0);
        check_val("rst_sta", {31'd0, sin_sta}, 32'd0);
        check_val("rst_theta", sin_theta, 32'd0);
        check_val("rst_rsp", {28'd0, rsp_valid}, 32'd0);
        check_val("rst_ack", {31'd0, halt_ack}, 32'd0);
        check_val("rst_inflight", {26'd0, inflight}, 32'd0);
        rst = 1'b0;

        // All four requesting continuously, including response/re-request overlap.
        for (int c = 0; c < 45; c++) begin
            tick();
            req = 4'b1111;
            #1;
            exp_g = (c < 4) ? 4'(1 << c) : (c >= 42 && c <= 44) ? 4'(1 << (c - 42)) : 4'b0;
            exp_r = (c >= 41 && c <= 44) ? 4'(1 << (c - 41)) : 4'b0;
            check_val("all_gnt", {28'd0, gnt}, {28'd0, exp_g});
            check_val("all_rsp", {28'd0, rsp_valid}, {28'd0, exp_r});
            if (c >= 41) check_val("all_rsp_sin", rsp_sin, sine_model(th[c-41]));
            if (c == 1) check_val("all_theta0", sin_theta, th[0]);
            if (c == 4) check_val("all_inflight_peak", {26'd0, inflight}, 32'd4);
        end

        // Halt with three operations outstanding; requester 3 keeps requesting.
        tick();
        req = 4'b1000; halt = 1'b1;
        #1;
        check_val("halt_gnt_same_cycle", {28'd0, gnt}, 32'd0);
        check_val("halt_inflight", {26'd0, inflight}, 32'd3);
        z = -1; h = -1; nr = 0; bad_g = 0;
        for (int c = 0; c < 100 && h < 0; c++) begin
            tick();
            #1;
            if (gnt != '0) bad_g++;
            if (rsp_valid != '0) nr++;
            if (inflight == 6'd0 && z < 0) z = cyc;
            if (halt_ack && h < 0) h = cyc;
        end
        check_val("halt_no_gnt", 32'(bad_g), 32'd0);
        check_val("halt_drain_rsps", 32'(nr), 32'd3);
        check_val("halt_ack_seen", {31'd0, h >= 0}, 32'd1);
        check_val("halt_ack_timing", 32'(h - z), 32'd1);
        tick();
        halt = 1'b0;
        #1;
        check_val("resume_gnt_wait", {28'd0, gnt}, 32'd0);
        check_val("resume_ack_still", {31'd0, halt_ack}, 32'd1);
        tick();
        #1;
        check_val("resume_gnt", {28'd0, gnt}, 32'b1000);
        check_val("resume_ack_low", {31'd0, halt_ack}, 32'd0);
        wait_rsp("resume_rsp", cyc, 4'b1000, sine_model(th[3]));

        // Single request of pi/2 from requester 1.
        tick();
        theta[1*32 +: 32] = 32'h3FC90FDB;
        req = 4'b0010;
        #1;
        check_val("single_gnt", {28'd0, gnt}, 32'b0010);
        g = cyc;
        tick();
        req = '0;
        #1;
        check_val("single_sta", {31'd0, sin_sta}, 32'd1);
        check_val("single_theta", sin_theta, 32'h3FC90FDB);
        wait_rsp("single_rsp", g, 4'b0010, 32'h3F800000);
        tick();
        req = 4'b0010;
        #1;
        check_val("single_pending_clear", {28'd0, gnt}, 32'b0010);
        check_val("single_inflight0", {26'd0, inflight}, 32'd0);
        wait_rsp("single_rsp2", cyc, 4'b0010, 32'h3F800000);

        // Fairness from rr_ptr=2 with req=1011.
        tick(); req = 4'b1011; #1;
        check_val("fair_gnt_a", {28'd0, gnt}, 32'b1000);
        tick(); #1;
        check_val("fair_gnt_b", {28'd0, gnt}, 32'b0001);
        tick(); #1;
        check_val("fair_gnt_c", {28'd0, gnt}, 32'b0010);
        tick(); req = '0; #1;
        check_val("fair_gnt_none", {28'd0, gnt}, 32'd0);
        order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b0010;
        nr = 0;
        for (int c = 0; c < 60; c++) begin
            tick(); #1;
            if (rsp_valid != '0) begin
                if (nr < 3) check_val("fair_rsp_order", {28'd0, rsp_valid}, {28'd0, order[nr]});
                nr++;
            end
        end
        check_val("fair_rsp_count", 32'(nr), 32'd3);

        // Reset with two operations in flight.
        tick(); req = 4'b0011; #1;
        check_val("rstmid_gnt0", {28'd0, gnt}, 32'b0001);
        tick(); #1;
        check_val("rstmid_gnt1", {28'd0, gnt}, 32'b0010);
        tick(); req = '0; #1;
        check_val("rstmid_inflight", {26'd0, inflight}, 32'd2);
        rst = 1'b1;
        #1;
        check_val("rstmid_inflight0", {26'd0, inflight}, 32'd0);
        check_val("rstmid_sta", {31'd0, sin_sta}, 32'd0);
        check_val("rstmid_theta", sin_theta, 32'd0);
        check_val("rstmid_rsp_sin", rsp_sin, 32'd0);
        tick(); tick();
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 50; c++) begin
            tick(); #1;
            if (rsp_valid != '0) stray++;
        end
        check_val("rstmid_no_stray_rsp", 32'(stray), 32'd0);
        tick(); req = 4'b0100; #1;
        check_val("post_rst_gnt", {28'd0, gnt}, 32'b0100);
        wait_rsp("post_rst_rsp", cyc, 4'b0100, sine_model(th[2]));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
